// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx among NUM_REQ byte streams.
// Loads the UART during its idle or last stop-bit cycle so consecutive frames leave no idle bit.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int LOCK_TIMEOUT = 0,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_din,
  input  logic                 tx_busy,
  input  logic                 tx_ready_flag,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout_pulse
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] rr_last;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] cand;
  logic             any_valid;
  logic [31:0]      stall_cnt;
  logic             hold_valid;
  logic             load_window;
  logic             stall;
  logic             timeout_hit;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    next_idx  = rr_last;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_last) + 32'(k)) % 32'(NUM_REQ));
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        next_idx  = cand;
      end
    end
  end

  // The UART is never assumed idle: a frame may still be running across our own reset.
  assign load_window = !tx_busy || tx_ready_flag;
  assign hold_valid  = req_valid[grant_idx];
  assign grant_valid = (state == LOCKED);
  assign tx_start    = grant_valid && load_window && hold_valid;
  assign tx_din      = req_data[{grant_idx, 3'b000} +: 8];
  assign req_ready   = tx_start ? (NUM_REQ'(1) << grant_idx) : '0;

  assign stall       = grant_valid && !hold_valid && !tx_busy;
  assign timeout_hit = (LOCK_TIMEOUT > 0) && stall &&
                       (stall_cnt == 32'(LOCK_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant_idx     <= '0;
      rr_last       <= IDX_W'(NUM_REQ - 1);
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (any_valid) begin
            grant_idx <= next_idx;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (tx_start) begin
            stall_cnt <= '0;
            if (req_last[grant_idx]) begin
              rr_last <= grant_idx;
              state   <= IDLE;
            end
          end else if (timeout_hit) begin
            // Abandon the partial packet; the holder's remaining bytes re-compete later.
            timeout_pulse <= 1'b1;
            rr_last       <= grant_idx;
            stall_cnt     <= '0;
            state         <= IDLE;
          end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural uart_tx (16 cycles/bit), byte-queue sources,
// a line decoder, and immediate-assertion checks against hand-computed frame/grant sequences.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 50;
  localparam int BIT_CYC = 16;
  localparam int FRAME   = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_busy = 1'b0;
  logic        tx_ready_flag;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic        timeout_pulse;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_din(tx_din), .tx_busy(tx_busy), .tx_ready_flag(tx_ready_flag),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_pulse(timeout_pulse)
  );

  // uart_tx model: no reset, accepts start when idle or in the last stop-bit cycle.
  logic [9:0]  u_frame = '1;
  logic [7:0]  u_cnt   = '0;
  logic        line;
  logic [7:0]  frame_q[$];
  logic        b2b_q[$];

  assign tx_ready_flag = tx_busy && (u_cnt == 8'(FRAME - 1));
  assign line          = tx_busy ? u_frame[u_cnt[7:4]] : 1'b1;

  always @(posedge clk) begin
    if (tx_start && (!tx_busy || tx_ready_flag)) begin
      frame_q.push_back(tx_din);
      b2b_q.push_back(tx_ready_flag);
      tx_busy <= 1'b1;
      u_cnt   <= '0;
      u_frame <= {1'b1, tx_din, 1'b0};
    end else if (tx_busy) begin
      if (u_cnt == 8'(FRAME - 1)) tx_busy <= 1'b0;
      else u_cnt <= u_cnt + 8'd1;
    end
  end

  // Handshake monitor, sampled mid-cycle.
  logic [3:0] acc = '0;
  int         svc_q[$];
  int         bad_ready = 0;
  int         bad_start = 0;

  always @(negedge clk) begin
    acc = req_valid & req_ready;
    if (tx_start) svc_q.push_back(int'(grant_idx));
    if (req_ready !== (tx_start ? (4'b0001 << grant_idx) : 4'b0000)) bad_ready++;
    if (tx_start && tx_busy && !tx_ready_flag) bad_start++;
  end

  // Byte sources: head of each queue is presented; popped after the edge that consumed it.
  logic [8:0] src_q[4][$];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      if (src_q[i].size() != 0) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = src_q[i][0][8];
        req_data[8*i +: 8] = src_q[i][0][7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
  end

  // Serial line decoder, samples at bit centres.
  logic [7:0] dec_q[$];
  logic       stop_q[$];
  logic [7:0] dec_b;

  initial forever begin
    @(negedge clk);
    if (line === 1'b0) begin
      repeat (BIT_CYC / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (BIT_CYC) @(negedge clk);
        dec_b[k] = line;
      end
      repeat (BIT_CYC) @(negedge clk);
      dec_q.push_back(dec_b);
      stop_q.push_back(line);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] exp_b[$];
  int         exp_s[$];
  logic       exp_f[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input int s, input logic f);
    exp_b.push_back(b);
    exp_s.push_back(s);
    exp_f.push_back(f);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_frames"},  32'(frame_q.size()), 32'(exp_b.size()));
    chk({tag, "_decoded"}, 32'(dec_q.size()),   32'(exp_b.size()));
    chk({tag, "_grants"},  32'(svc_q.size()),   32'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++) begin
      chk($sformatf("%s_din%0d", tag, i),
          (i < frame_q.size()) ? 32'(frame_q[i]) : 32'hxxxx_xxxx, 32'(exp_b[i]));
      chk($sformatf("%s_line%0d", tag, i),
          (i < dec_q.size()) ? 32'(dec_q[i]) : 32'hxxxx_xxxx, 32'(exp_b[i]));
      chk($sformatf("%s_stop%0d", tag, i),
          (i < stop_q.size()) ? 32'(stop_q[i]) : 32'hxxxx_xxxx, 32'd1);
      chk($sformatf("%s_holder%0d", tag, i),
          (i < svc_q.size()) ? 32'(svc_q[i]) : 32'hxxxx_xxxx, 32'(exp_s[i]));
      chk($sformatf("%s_b2b%0d", tag, i),
          (i < b2b_q.size()) ? 32'(b2b_q[i]) : 32'hxxxx_xxxx, 32'(exp_f[i]));
    end
    exp_b.delete();
    exp_s.delete();
    exp_f.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0 ||
            tx_busy || grant_valid || req_valid != 4'b0000) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_drained"}, 32'(n < 5000), 32'd1);
  endtask

  task automatic wait_frames(input string tag, input int cnt);
    int n = 0;
    while (frame_q.size() < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_frame_started"}, 32'(frame_q.size() >= cnt), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame_q.delete(); b2b_q.delete(); dec_q.delete(); stop_q.delete(); svc_q.delete();
  endtask

  initial begin
    int wrong;
    int stall;
    int n;

    // Reset state, with a request pending that must not be served while in reset.
    rst = 1'b1;
    @(negedge clk);
    src_q[2].push_back(9'h1EE);
    repeat (3) @(negedge clk);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    chk("rst_req_valid_seen", 32'(req_valid), 32'h4);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    src_q[2].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single last byte from req0; IDLE cycle, then one-cycle accept strobe.
    src_q[0].push_back(9'h141);
    n = 0;
    while (!req_valid[0] && n < 10) begin @(negedge clk); n++; end
    chk("t1_valid_seen", 32'(req_valid[0]), 32'd1);
    chk("t1_ready_idle_cycle", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("t1_ready_pulse", 32'(req_ready), 32'h1);
    chk("t1_grant_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    chk("t1_ready_drop", 32'(req_ready), 32'd0);
    wait_idle("t1");
    expect_frame(8'h41, 0, 1'b0);
    chk_log("t1");

    // 2: three-byte packet from req1, lock held throughout, frames back-to-back.
    do_reset();
    src_q[1].push_back(9'h010);
    src_q[1].push_back(9'h011);
    src_q[1].push_back(9'h112);
    wrong = 0;
    n = 0;
    while (frame_q.size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (frame_q.size() inside {[1:2]} && !(grant_valid && grant_idx == 2'd1)) wrong++;
    end
    chk("t2_lock_held", 32'(wrong), 32'd0);
    wait_idle("t2");
    expect_frame(8'h10, 1, 1'b0);
    expect_frame(8'h11, 1, 1'b1);
    expect_frame(8'h12, 1, 1'b1);
    chk_log("t2");

    // 3: all four requesters valid; rotation 0,1,2,3 then back to 0.
    do_reset();
    src_q[0].push_back(9'h1A0);
    src_q[0].push_back(9'h1A4);
    src_q[1].push_back(9'h1A1);
    src_q[2].push_back(9'h1A2);
    src_q[3].push_back(9'h1A3);
    wait_idle("t3");
    expect_frame(8'hA0, 0, 1'b0);
    expect_frame(8'hA1, 1, 1'b1);
    expect_frame(8'hA2, 2, 1'b1);
    expect_frame(8'hA3, 3, 1'b1);
    expect_frame(8'hA4, 0, 1'b1);
    chk_log("t3");

    // 4: req3 waits until req2's whole packet has gone.
    do_reset();
    src_q[2].push_back(9'h020);
    src_q[2].push_back(9'h021);
    src_q[2].push_back(9'h122);
    src_q[3].push_back(9'h130);
    wait_idle("t4");
    expect_frame(8'h20, 2, 1'b0);
    expect_frame(8'h21, 2, 1'b1);
    expect_frame(8'h22, 2, 1'b1);
    expect_frame(8'h30, 3, 1'b1);
    chk_log("t4");

    // 5: req1 stalls mid-packet; forced release after 50 idle stall cycles, req2 next.
    do_reset();
    src_q[1].push_back(9'h050);
    wait_frames("t5", 1);
    src_q[2].push_back(9'h160);
    stall = 0;
    n = 0;
    while (!timeout_pulse && n < 2000) begin
      @(negedge clk);
      n++;
      if (!timeout_pulse && grant_valid && grant_idx == 2'd1 && !tx_busy && !req_valid[1]) stall++;
    end
    chk("t5_pulse_seen", 32'(timeout_pulse), 32'd1);
    chk("t5_stall_cycles", 32'(stall), 32'd50);
    chk("t5_released", 32'(grant_valid), 32'd0);
    @(negedge clk);
    chk("t5_pulse_width", 32'(timeout_pulse), 32'd0);
    chk("t5_regrant_valid", 32'(grant_valid), 32'd1);
    chk("t5_regrant_idx", 32'(grant_idx), 32'd2);
    src_q[1].push_back(9'h151);
    wait_idle("t5");
    expect_frame(8'h50, 1, 1'b0);
    expect_frame(8'h60, 2, 1'b0);
    expect_frame(8'h51, 1, 1'b1);
    chk_log("t5");

    // 6: reset while 0xA5 is on the line; frame completes, next launch waits for a legal window.
    do_reset();
    src_q[0].push_back(9'h0A5);
    wait_frames("t6", 1);
    repeat (40) @(negedge clk);
    chk("t6_locked_before_rst", 32'(grant_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_grant_valid_in_rst", 32'(grant_valid), 32'd0);
    chk("t6_tx_start_in_rst", 32'(tx_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    src_q[3].push_back(9'h1B6);
    wait_idle("t6");
    expect_frame(8'hA5, 0, 1'b0);
    expect_frame(8'hB6, 3, 1'b1);
    chk_log("t6");

    chk("no_start_while_busy", 32'(bad_start), 32'd0);
    chk("ready_onehot_track", 32'(bad_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
